// File: rtl/uip_axi_burst_bridge.sv
// UIP request responder: runs one fixed-length AXI4 INCR read burst and one write
// burst at a time on independent channels, with packed rd/wr buffers and done pulses.
module uip_axi_burst_bridge #(
    parameter int ADDR_WIDTH           = 32,
    parameter int READ_BURST_LEN       = 8,
    parameter int C_S_AXIS_TDATA_WIDTH = 128,
    parameter int WRITE_BURST_LEN      = 8,
    parameter int C_M_AXIS_TDATA_WIDTH = 128
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             uip2axi_rd_en,
    input  logic [ADDR_WIDTH-1:0]                            uip2axi_rd_addr,
    output logic                                             axi2uip_rd_done,
    output logic [READ_BURST_LEN*C_S_AXIS_TDATA_WIDTH-1:0]   rd_buffer,
    input  logic                                             uip2axi_wr_en,
    input  logic [ADDR_WIDTH-1:0]                            uip2axi_wr_addr,
    input  logic [WRITE_BURST_LEN*C_M_AXIS_TDATA_WIDTH-1:0]  wr_buffer,
    output logic                                             axi2uip_wr_done,
    output logic                                             rd_err,
    output logic                                             wr_err,
    output logic [ADDR_WIDTH-1:0]                            m_axi_araddr,
    output logic [7:0]                                       m_axi_arlen,
    output logic [2:0]                                       m_axi_arsize,
    output logic [1:0]                                       m_axi_arburst,
    output logic                                             m_axi_arvalid,
    input  logic                                             m_axi_arready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]                  m_axi_rdata,
    input  logic [1:0]                                       m_axi_rresp,
    input  logic                                             m_axi_rlast,
    input  logic                                             m_axi_rvalid,
    output logic                                             m_axi_rready,
    output logic [ADDR_WIDTH-1:0]                            m_axi_awaddr,
    output logic [7:0]                                       m_axi_awlen,
    output logic [2:0]                                       m_axi_awsize,
    output logic [1:0]                                       m_axi_awburst,
    output logic                                             m_axi_awvalid,
    input  logic                                             m_axi_awready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]                  m_axi_wdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                m_axi_wstrb,
    output logic                                             m_axi_wlast,
    output logic                                             m_axi_wvalid,
    input  logic                                             m_axi_wready,
    input  logic [1:0]                                       m_axi_bresp,
    input  logic                                             m_axi_bvalid,
    output logic                                             m_axi_bready,
    output logic [1:0]                                       o_dbg_rd_state,
    output logic [2:0]                                       o_dbg_wr_state
);

    localparam int RD_BUF_LEN = READ_BURST_LEN * C_S_AXIS_TDATA_WIDTH;
    localparam int WR_BUF_LEN = WRITE_BURST_LEN * C_M_AXIS_TDATA_WIDTH;
    localparam int RCW = (READ_BURST_LEN > 1) ? $clog2(READ_BURST_LEN) : 1;
    localparam int WCW = (WRITE_BURST_LEN > 1) ? $clog2(WRITE_BURST_LEN) : 1;
    localparam logic [RCW-1:0] RD_LAST = RCW'(READ_BURST_LEN - 1);
    localparam logic [WCW-1:0] WR_LAST = WCW'(WRITE_BURST_LEN - 1);
    localparam logic [1:0]     RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_t;
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} wr_state_t;

    rd_state_t                 r_rd_state, w_rd_state_nxt;
    wr_state_t                 r_wr_state, w_wr_state_nxt;
    logic                      r_rd_en_q, r_wr_en_q;
    logic [ADDR_WIDTH-1:0]     r_araddr, r_awaddr;
    logic [RCW-1:0]            r_rd_cnt;
    logic [WCW-1:0]            r_wr_cnt;
    logic [RD_BUF_LEN-1:0]     r_rd_buffer;
    logic [WR_BUF_LEN-1:0]     r_wr_buffer;
    logic                      r_rd_err, r_wr_err;

    logic w_rd_req, w_wr_req, w_r_beat, w_w_beat, w_b_hs;
    logic w_rd_cnt_last, w_wr_cnt_last;

    // Every channel transfers on a cycle where valid and ready are both high; a
    // raised valid and its payload stay unchanged until that transfer happens.
    assign w_rd_req      = uip2axi_rd_en & ~r_rd_en_q;
    assign w_wr_req      = uip2axi_wr_en & ~r_wr_en_q;
    assign w_r_beat      = m_axi_rvalid & m_axi_rready;
    assign w_w_beat      = m_axi_wvalid & m_axi_wready;
    assign w_b_hs        = m_axi_bvalid & m_axi_bready;
    assign w_rd_cnt_last = (r_rd_cnt == RD_LAST);
    assign w_wr_cnt_last = (r_wr_cnt == WR_LAST);

    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = 8'(READ_BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(C_S_AXIS_TDATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = 8'(WRITE_BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(C_M_AXIS_TDATA_WIDTH / 8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
    assign m_axi_wdata   = r_wr_buffer[int'(r_wr_cnt)*C_M_AXIS_TDATA_WIDTH +: C_M_AXIS_TDATA_WIDTH];
    assign rd_buffer     = r_rd_buffer;
    assign rd_err        = r_rd_err;
    assign wr_err        = r_wr_err;
    assign o_dbg_rd_state = r_rd_state;
    assign o_dbg_wr_state = r_wr_state;

    always_ff @(posedge clk) begin
        if (rst) r_rd_state <= R_IDLE;
        else     r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_rd_req) w_rd_state_nxt = R_ADDR;
            R_ADDR:  if (m_axi_arready) w_rd_state_nxt = R_DATA;
            // The beat counter, not rlast, decides where the burst ends.
            R_DATA:  if (w_r_beat && w_rd_cnt_last) w_rd_state_nxt = R_DONE;
            R_DONE:  w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        m_axi_arvalid   = (r_rd_state == R_ADDR);
        m_axi_rready    = (r_rd_state == R_DATA);
        axi2uip_rd_done = (r_rd_state == R_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_en_q   <= 1'b0;
            r_araddr    <= '0;
            r_rd_cnt    <= '0;
            r_rd_buffer <= '0;
            r_rd_err    <= 1'b0;
        end else begin
            r_rd_en_q <= uip2axi_rd_en;
            if (r_rd_state == R_IDLE && w_rd_req) begin
                r_araddr <= uip2axi_rd_addr;
                r_rd_cnt <= '0;
            end
            if (w_r_beat) begin
                r_rd_buffer[int'(r_rd_cnt)*C_S_AXIS_TDATA_WIDTH +: C_S_AXIS_TDATA_WIDTH] <= m_axi_rdata;
                if (!w_rd_cnt_last) r_rd_cnt <= r_rd_cnt + 1'b1;
                if (m_axi_rresp != RESP_OKAY || m_axi_rlast != w_rd_cnt_last) r_rd_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_wr_state <= W_IDLE;
        else     r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_wr_req) w_wr_state_nxt = W_ADDR;
            W_ADDR:  if (m_axi_awready) w_wr_state_nxt = W_DATA;
            W_DATA:  if (w_w_beat && w_wr_cnt_last) w_wr_state_nxt = W_RESP;
            W_RESP:  if (m_axi_bvalid) w_wr_state_nxt = W_DONE;
            W_DONE:  w_wr_state_nxt = W_IDLE;
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid   = (r_wr_state == W_ADDR);
        m_axi_wvalid    = (r_wr_state == W_DATA);
        m_axi_wlast     = (r_wr_state == W_DATA) && w_wr_cnt_last;
        m_axi_bready    = (r_wr_state == W_RESP);
        axi2uip_wr_done = (r_wr_state == W_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en_q   <= 1'b0;
            r_awaddr    <= '0;
            r_wr_cnt    <= '0;
            r_wr_buffer <= '0;
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_en_q <= uip2axi_wr_en;
            if (r_wr_state == W_IDLE && w_wr_req) begin
                r_awaddr    <= uip2axi_wr_addr;
                r_wr_buffer <= wr_buffer;
                r_wr_cnt    <= '0;
            end
            if (w_w_beat && !w_wr_cnt_last) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_b_hs && m_axi_bresp != RESP_OKAY) r_wr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uip_axi_burst_bridge.sv
// Bench for uip_axi_burst_bridge: AXI responder with random stalls plus a
// transaction-level model compared against the DUT every cycle.
module tb_uip_axi_burst_bridge;

    localparam int AW = 32, RL = 8, RW = 128, WL = 8, WW = 128;
    localparam int RB = RL * RW, WB = WL * WW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_en = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic [WB-1:0] wr_buffer = '0;
    logic rd_done, wr_done, rd_err, wr_err;
    logic [RB-1:0] rd_buffer;
    logic [AW-1:0] m_axi_araddr, m_axi_awaddr;
    logic [7:0] m_axi_arlen, m_axi_awlen;
    logic [2:0] m_axi_arsize, m_axi_awsize;
    logic [1:0] m_axi_arburst, m_axi_awburst;
    logic m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
    logic m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
    logic [RW-1:0] m_axi_rdata = '0;
    logic [1:0] m_axi_rresp = 2'b00, m_axi_bresp = 2'b00;
    logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic [WW-1:0] m_axi_wdata;
    logic [WW/8-1:0] m_axi_wstrb;
    logic [1:0] dbg_rd_state;
    logic [2:0] dbg_wr_state;

    uip_axi_burst_bridge #(
        .ADDR_WIDTH(AW), .READ_BURST_LEN(RL), .C_S_AXIS_TDATA_WIDTH(RW),
        .WRITE_BURST_LEN(WL), .C_M_AXIS_TDATA_WIDTH(WW)
    ) dut (
        .clk(clk), .rst(rst),
        .uip2axi_rd_en(rd_en), .uip2axi_rd_addr(rd_addr),
        .axi2uip_rd_done(rd_done), .rd_buffer(rd_buffer),
        .uip2axi_wr_en(wr_en), .uip2axi_wr_addr(wr_addr), .wr_buffer(wr_buffer),
        .axi2uip_wr_done(wr_done), .rd_err(rd_err), .wr_err(wr_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .o_dbg_rd_state(dbg_rd_state), .o_dbg_wr_state(dbg_wr_state)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state
    bit m_rd_en_prev, m_wr_en_prev;
    bit rd_busy, ar_pend, rd_data_ph, rd_done_exp, rd_err_exp;
    logic [AW-1:0] rd_addr_exp;
    int rd_got;
    logic [RB-1:0] rd_buf_exp;
    bit wr_busy, aw_pend, w_active, b_wait, wr_done_exp, wr_err_exp;
    logic [AW-1:0] wr_addr_exp;
    logic [WW-1:0] exp_q[$];

    // Responder state and knobs
    int sl_rd_left, sl_beat;
    bit sl_rvalid, sl_bvalid;
    int stall_pct = 0;
    bit pat_mode = 0;
    int err_beat = -1;

    // Observations used for synchronisation and literal checks
    int cyc = 0, rd_done_cnt = 0, wr_done_cnt = 0, ar_hs_cnt = 0, rd_drop_cnt = 0;
    int rd_acc_cyc = 0, wr_acc_cyc = 0, rd_done_cyc = 0, wr_done_cyc = 0;
    int wlast_hs_cnt = 0, w_beat_idx = 0;
    logic [WW-1:0] w_first_data = '0;

    function automatic bit rnd_ok();
        return ($urandom_range(0, 99) >= stall_pct);
    endfunction

    initial begin
        bit rd_edge, wr_edge, old_rd_busy, old_wr_busy, nxt_rd_done, nxt_wr_done;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            m_axi_arready = rnd_ok();
            if (!sl_rvalid && sl_rd_left > 0 && rnd_ok()) begin
                sl_rvalid   = 1'b1;
                m_axi_rdata = pat_mode ? {16{8'(sl_beat + 1)}} : {$urandom, $urandom, $urandom, $urandom};
                m_axi_rresp = (sl_beat == err_beat) ? 2'b10 : 2'b00;
                m_axi_rlast = (sl_beat == RL - 1);
            end
            m_axi_rvalid  = sl_rvalid;
            m_axi_awready = rnd_ok();
            m_axi_wready  = rnd_ok();
            if (!sl_bvalid && b_wait && rnd_ok()) sl_bvalid = 1'b1;
            m_axi_bvalid = sl_bvalid;
            m_axi_bresp  = 2'b00;
            #1;
            chk("arvalid", 128'(m_axi_arvalid), 128'(ar_pend));
            if (ar_pend) begin
                chk("araddr", 128'(m_axi_araddr), 128'(rd_addr_exp));
                chk("arlen", 128'(m_axi_arlen), 128'(RL - 1));
                chk("arsize", 128'(m_axi_arsize), 128'($clog2(RW / 8)));
                chk("arburst", 128'(m_axi_arburst), 128'(2'b01));
            end
            chk("rready", 128'(m_axi_rready), 128'(rd_data_ph));
            chk("rd_done", 128'(rd_done), 128'(rd_done_exp));
            chk("rd_err", 128'(rd_err), 128'(rd_err_exp));
            if (!rd_busy || rd_done_exp)
                for (int k = 0; k < RL; k++)
                    chk("rd_buffer", rd_buffer[k*RW +: RW], rd_buf_exp[k*RW +: RW]);
            chk("awvalid", 128'(m_axi_awvalid), 128'(aw_pend));
            if (aw_pend) begin
                chk("awaddr", 128'(m_axi_awaddr), 128'(wr_addr_exp));
                chk("awlen", 128'(m_axi_awlen), 128'(WL - 1));
                chk("awsize", 128'(m_axi_awsize), 128'($clog2(WW / 8)));
                chk("awburst", 128'(m_axi_awburst), 128'(2'b01));
            end
            chk("wvalid", 128'(m_axi_wvalid), 128'(w_active && exp_q.size() > 0));
            if (w_active && exp_q.size() > 0) begin
                chk("wdata", m_axi_wdata, exp_q[0]);
                chk("wlast", 128'(m_axi_wlast), 128'(exp_q.size() == 1));
                chk("wstrb", 128'(m_axi_wstrb), 128'({(WW/8){1'b1}}));
            end
            chk("bready", 128'(m_axi_bready), 128'(b_wait));
            chk("wr_done", 128'(wr_done), 128'(wr_done_exp));
            chk("wr_err", 128'(wr_err), 128'(wr_err_exp));
            if (rd_done) begin rd_done_cnt++; rd_done_cyc = cyc; end
            if (wr_done) begin wr_done_cnt++; wr_done_cyc = cyc; end

            if (rst) begin
                m_rd_en_prev = 0; m_wr_en_prev = 0;
                rd_busy = 0; ar_pend = 0; rd_data_ph = 0; rd_done_exp = 0; rd_err_exp = 0;
                rd_got = 0; rd_buf_exp = '0;
                wr_busy = 0; aw_pend = 0; w_active = 0; b_wait = 0; wr_done_exp = 0; wr_err_exp = 0;
                exp_q.delete();
                sl_rd_left = 0; sl_beat = 0; sl_rvalid = 0; sl_bvalid = 0;
            end else begin
                nxt_rd_done = 0;
                nxt_wr_done = 0;
                rd_edge = rd_en && !m_rd_en_prev;
                wr_edge = wr_en && !m_wr_en_prev;
                old_rd_busy = rd_busy;
                old_wr_busy = wr_busy;
                if (rd_done_exp) rd_busy = 0;
                if (wr_done_exp) wr_busy = 0;
                if (rd_edge) begin
                    if (!old_rd_busy) begin
                        rd_busy = 1; ar_pend = 1; rd_addr_exp = rd_addr; rd_acc_cyc = cyc;
                    end else rd_drop_cnt++;
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_hs_cnt++; ar_pend = 0; rd_data_ph = 1; rd_got = 0;
                    sl_rd_left = RL; sl_beat = 0;
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    if (rd_got < RL) rd_buf_exp[rd_got*RW +: RW] = m_axi_rdata;
                    if (m_axi_rresp != 2'b00) rd_err_exp = 1;
                    rd_got++;
                    sl_rvalid = 0; sl_beat++; sl_rd_left--;
                    if (rd_got == RL) begin rd_data_ph = 0; nxt_rd_done = 1; end
                end
                rd_done_exp = nxt_rd_done;

                if (wr_edge && !old_wr_busy) begin
                    wr_busy = 1; aw_pend = 1; w_active = 0; wr_addr_exp = wr_addr;
                    wr_acc_cyc = cyc; w_beat_idx = 0;
                    for (int k = 0; k < WL; k++) exp_q.push_back(wr_buffer[k*WW +: WW]);
                end
                if (m_axi_awvalid && m_axi_awready) begin aw_pend = 0; w_active = 1; end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (w_beat_idx == 0) w_first_data = m_axi_wdata;
                    w_beat_idx++;
                    if (m_axi_wlast) wlast_hs_cnt++;
                    if (exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin w_active = 0; b_wait = 1; end
                    end
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    sl_bvalid = 0; b_wait = 0; nxt_wr_done = 1;
                    if (m_axi_bresp != 2'b00) wr_err_exp = 1;
                end
                wr_done_exp = nxt_wr_done;
                m_rd_en_prev = rd_en;
                m_wr_en_prev = wr_en;
            end
        end
    end

    task automatic pulse_rd(input logic [AW-1:0] a);
        @(posedge clk); #1;
        rd_addr = a; rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_wr(input logic [AW-1:0] a, input logic [WB-1:0] b);
        @(posedge clk); #1;
        wr_addr = a; wr_buffer = b; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_rd(input int start);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #3;
            if (rd_done_cnt != start) ok = 1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rd_timeout: got no rd_done expected one"); end
    endtask

    task automatic wait_wr(input int start);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #3;
            if (wr_done_cnt != start) ok = 1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL wr_timeout: got no wr_done expected one"); end
    endtask

    task automatic check_reset_vals();
        chk("rst_arvalid", 128'(m_axi_arvalid), 0);
        chk("rst_rready", 128'(m_axi_rready), 0);
        chk("rst_awvalid", 128'(m_axi_awvalid), 0);
        chk("rst_wvalid", 128'(m_axi_wvalid), 0);
        chk("rst_bready", 128'(m_axi_bready), 0);
        chk("rst_rd_done", 128'(rd_done), 0);
        chk("rst_wr_done", 128'(wr_done), 0);
        chk("rst_rd_err", 128'(rd_err), 0);
        chk("rst_wr_err", 128'(wr_err), 0);
        chk("rst_araddr", 128'(m_axi_araddr), 0);
        chk("rst_awaddr", 128'(m_axi_awaddr), 0);
        chk("rst_wdata", m_axi_wdata, 0);
        for (int k = 0; k < RL; k++) chk("rst_rd_buffer", rd_buffer[k*RW +: RW], 0);
    endtask

    function automatic logic [WB-1:0] rand_buf();
        logic [WB-1:0] b;
        for (int i = 0; i < WB / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a = $urandom;
        a[3:0] = 4'h0;
        return a;
    endfunction

    initial begin
        logic [7:0] pat [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hA5, 8'h5A};
        logic [WB-1:0] wb;
        int s, s2, a0, d0, wl0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #3;
        check_reset_vals();

        // Directed read with incrementing byte pattern, no stalls
        pat_mode = 1;
        s = rd_done_cnt;
        pulse_rd(32'h1000_0000);
        #2;
        chk("lit_arvalid", 128'(m_axi_arvalid), 1);
        chk("lit_araddr", 128'(m_axi_araddr), 128'h1000_0000);
        chk("lit_arlen", 128'(m_axi_arlen), 7);
        chk("lit_arsize", 128'(m_axi_arsize), 4);
        chk("lit_arburst", 128'(m_axi_arburst), 1);
        wait_rd(s);
        chk("lit_rd_beat0", rd_buffer[127:0], {16{8'h01}});
        chk("lit_rd_beat7", rd_buffer[1023:896], {16{8'h08}});
        chk("lit_rd_latency", 128'(rd_done_cyc - rd_acc_cyc), 10);
        pat_mode = 0;

        // Directed write of AA.., BB.., ... beats
        for (int k = 0; k < WL; k++) wb[k*WW +: WW] = {16{pat[k]}};
        s = wr_done_cnt;
        wl0 = wlast_hs_cnt;
        pulse_wr(32'h2000_0080, wb);
        #2;
        chk("lit_awvalid", 128'(m_axi_awvalid), 1);
        chk("lit_awaddr", 128'(m_axi_awaddr), 128'h2000_0080);
        wait_wr(s);
        chk("lit_w_beat0", w_first_data, {16{8'hAA}});
        chk("lit_wlast_count", 128'(wlast_hs_cnt - wl0), 1);
        chk("lit_wr_latency", 128'(wr_done_cyc - wr_acc_cyc), 11);

        // Concurrent read and write edges in the same cycle
        s = rd_done_cnt;
        s2 = wr_done_cnt;
        @(posedge clk); #1;
        rd_addr = 32'h0000_4000; wr_addr = 32'h0000_8000; wr_buffer = rand_buf();
        rd_en = 1'b1; wr_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        wait_rd(s);
        wait_wr(s2);

        // Second rising edge while the read burst is in its data phase
        s = rd_done_cnt; a0 = ar_hs_cnt; d0 = rd_drop_cnt;
        pulse_rd(32'h0000_1230);
        repeat (3) @(posedge clk);
        pulse_rd(32'h0000_5670);
        wait_rd(s);
        repeat (15) @(posedge clk);
        #3;
        chk("drop_ar_count", 128'(ar_hs_cnt - a0), 1);
        chk("drop_done_count", 128'(rd_done_cnt - s), 1);
        chk("drop_edge_seen", 128'(rd_drop_cnt - d0), 1);

        // Random stalls on every channel, reads and writes running side by side
        stall_pct = 30;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int st = rd_done_cnt;
                    pulse_rd(rand_addr());
                    wait_rd(st);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                for (int j = 0; j < 100; j++) begin
                    int st = wr_done_cnt;
                    pulse_wr(rand_addr(), rand_buf());
                    wait_wr(st);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
        join
        stall_pct = 0;
        repeat (5) @(posedge clk);

        // Error response on beat 3, sticky across a clean burst
        err_beat = 3;
        s = rd_done_cnt;
        pulse_rd(32'h0000_9000);
        wait_rd(s);
        err_beat = -1;
        #1;
        chk("lit_rd_err_set", 128'(rd_err), 1);
        s = rd_done_cnt;
        pulse_rd(32'h0000_A000);
        wait_rd(s);
        #1;
        chk("lit_rd_err_sticky", 128'(rd_err), 1);

        // Reset in the middle of a write burst
        pulse_wr(32'h0000_B000, rand_buf());
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check_reset_vals();

        // Recovery after reset
        s = rd_done_cnt;
        s2 = wr_done_cnt;
        pulse_rd(32'h0000_C000);
        wait_rd(s);
        pulse_wr(32'h0000_D000, rand_buf());
        wait_wr(s2);
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
